adc_spi_capture: RTL and testbench

Upstream front end for the ADC sample FIFO: drives the serial interface of a 12-bit SPI ADC (16-clock frame, 4 leading zeros, MSB first), deserialises each conversion and pushes it into the FIFO write port as one 12-bit word per frame. Frames arriving while the FIFO reports full are dropped and counted. Malformed frames (nonzero leading bits) are discarded and flagged.

---
 rtl/adc_spi_capture.sv | 200 ++++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// SPI front end for a 12-bit ADC: frames each conversion, deserialises it MSB first
// and pushes one word per frame into the sample FIFO, tracking drops and bad frames.
module adc_spi_capture #(
    parameter int DATA_WIDTH   = 12,
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_ZEROS   = 4,
    parameter int CLK_DIV      = 4,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  adc_sdo_i,
    input  logic                  fifo_full_i,
    output logic                  adc_cs_n_o,
    output logic                  adc_sclk_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  wren_o,
    output logic [7:0]            drop_cnt_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_DONE,
        ST_QUIET
    } state_t;

    localparam int CNT_MAX = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
    localparam logic [4:0]       BIT_LAST   = 5'(FRAME_BITS);

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = value + 8'd1;
        end
    endfunction

    state_t                  state_r,     state_s;
    logic [CNT_W-1:0]        cnt_r,       cnt_s;
    logic [4:0]              bit_cnt_r,   bit_cnt_s;
    logic [FRAME_BITS-1:0]   shift_r,     shift_s;
    logic                    cs_n_r,      cs_n_s;
    logic                    sclk_r,      sclk_s;
    logic [DATA_WIDTH-1:0]   wdata_r,     wdata_s;
    logic                    wren_r,      wren_s;
    logic [7:0]              drop_cnt_r,  drop_cnt_s;
    logic                    overrun_r,   overrun_s;
    logic                    frame_err_r, frame_err_s;
    logic [7:0]              drop_base_s;
    logic                    lead_err_s;

    // Next-state, counter and registered-output decode; outputs are computed for the next cycle.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bit_cnt_s   = bit_cnt_r;
        shift_s     = shift_r;
        cs_n_s      = cs_n_r;
        sclk_s      = sclk_r;
        wdata_s     = wdata_r;
        wren_s      = 1'b0;
        lead_err_s  = |shift_r[FRAME_BITS-1 -: LEAD_ZEROS];
        // A clear coinciding with a new event leaves that event visible.
        if (clr_i) begin
            drop_base_s = 8'd0;
            overrun_s   = 1'b0;
            frame_err_s = 1'b0;
        end else begin
            drop_base_s = drop_cnt_r;
            overrun_s   = overrun_r;
            frame_err_s = frame_err_r;
        end
        drop_cnt_s = drop_base_s;

        case (state_r)
            ST_IDLE: begin
                cs_n_s = 1'b1;
                sclk_s = 1'b1;
                cnt_s  = CNT_ZERO;
                if (en_i) begin
                    state_s = ST_CS_SETUP;
                    cs_n_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_r == DIV_LAST) begin
                    state_s   = ST_SHIFT;
                    cnt_s     = CNT_ZERO;
                    bit_cnt_s = 5'd0;
                    sclk_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != DIV_LAST) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = CNT_ZERO;
                    if (!sclk_r) begin
                        // This edge raises SCLK, so it is also the data sampling edge.
                        sclk_s    = 1'b1;
                        shift_s   = {shift_r[FRAME_BITS-2:0], adc_sdo_i};
                        bit_cnt_s = bit_cnt_r + 5'd1;
                    end else if (bit_cnt_r == BIT_LAST) begin
                        state_s = ST_DONE;
                        cs_n_s  = 1'b1;
                        if (lead_err_s) begin
                            frame_err_s = 1'b1;
                        end else if (!fifo_full_i) begin
                            wdata_s = shift_r[DATA_WIDTH-1:0];
                            wren_s  = 1'b1;
                        end else begin
                            drop_cnt_s = sat_inc(drop_base_s);
                            overrun_s  = 1'b1;
                        end
                    end else begin
                        sclk_s = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_QUIET;
                cnt_s   = CNT_ZERO;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b1;
            end
            ST_QUIET: begin
                if (cnt_r == QUIET_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (en_i) begin
                        state_s = ST_CS_SETUP;
                        cs_n_s  = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                cs_n_s  = 1'b1;
                sclk_s  = 1'b1;
            end
        endcase
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            bit_cnt_r   <= 5'd0;
            shift_r     <= {FRAME_BITS{1'b0}};
            cs_n_r      <= 1'b1;
            sclk_r      <= 1'b1;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wren_r      <= 1'b0;
            drop_cnt_r  <= 8'd0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            bit_cnt_r   <= bit_cnt_s;
            shift_r     <= shift_s;
            cs_n_r      <= cs_n_s;
            sclk_r      <= sclk_s;
            wdata_r     <= wdata_s;
            wren_r      <= wren_s;
            drop_cnt_r  <= drop_cnt_s;
            overrun_r   <= overrun_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign adc_cs_n_o  = cs_n_r;
    assign adc_sclk_o  = sclk_r;
    assign wdata_o     = wdata_r;
    assign wren_o      = wren_r;
    assign drop_cnt_o  = drop_cnt_r;
    assign overrun_o   = overrun_r;
    assign frame_err_o = frame_err_r;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Directed self-checking bench for adc_spi_capture with a behavioural SPI ADC model.
module tb_adc_spi_capture;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic        clr_i;
    logic        adc_sdo_i;
    logic        fifo_full_i;
    logic        adc_cs_n_o;
    logic        adc_sclk_o;
    logic [11:0] wdata_o;
    logic        wren_o;
    logic [7:0]  drop_cnt_o;
    logic        overrun_o;
    logic        frame_err_o;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int cs_low      = 0;
    int rises       = 0;
    int wren_cnt    = 0;
    logic prev_sclk = 1'b1;
    logic [15:0] adc_word = 16'h0000;

    adc_spi_capture dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .clr_i       (clr_i),
        .adc_sdo_i   (adc_sdo_i),
        .fifo_full_i (fifo_full_i),
        .adc_cs_n_o  (adc_cs_n_o),
        .adc_sclk_o  (adc_sclk_o),
        .wdata_o     (wdata_o),
        .wren_o      (wren_o),
        .drop_cnt_o  (drop_cnt_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ADC model: latches adc_word at cs_n fall, presents the next bit after each SCLK rise.
    initial begin
        logic        m_prev_cs;
        logic        m_prev_sclk;
        logic [4:0]  m_idx;
        logic [15:0] m_cur;
        m_prev_cs   = 1'b1;
        m_prev_sclk = 1'b1;
        m_idx       = 5'd0;
        m_cur       = 16'h0000;
        adc_sdo_i   = 1'b0;
        forever begin
            @(negedge clk);
            if (adc_cs_n_o !== 1'b0) begin
                m_idx = 5'd0;
            end else if (m_prev_cs === 1'b1) begin
                m_cur = adc_word;
                m_idx = 5'd0;
            end else if (m_prev_sclk === 1'b0 && adc_sclk_o === 1'b1) begin
                m_idx = m_idx + 5'd1;
            end
            adc_sdo_i   = (adc_cs_n_o === 1'b0 && m_idx < 5'd16) ? m_cur[4'd15 - m_idx[3:0]] : 1'b0;
            m_prev_cs   = adc_cs_n_o;
            m_prev_sclk = adc_sclk_o;
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (adc_cs_n_o === 1'b0) cs_low++;
        if (prev_sclk === 1'b0 && adc_sclk_o === 1'b1) rises++;
        if (wren_o === 1'b1) wren_cnt++;
        prev_sclk = adc_sclk_o;
    endtask

    task automatic clear_stats();
        cs_low   = 0;
        rises    = 0;
        wren_cnt = 0;
    endtask

    task automatic wait_wren(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step_cycle();
            if (wren_o === 1'b1) ok = 1'b1;
        end
    endtask

    // Advances to the DONE cycle of the current or next frame (cs_n low then high).
    task automatic wait_frame_end(input int budget, output bit ok);
        bit seen_low;
        ok       = 1'b0;
        seen_low = (adc_cs_n_o === 1'b0);
        for (int i = 0; i < budget && !ok; i++) begin
            step_cycle();
            if (adc_cs_n_o === 1'b0) seen_low = 1'b1;
            else if (seen_low) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en_i = 1'b0; clr_i = 1'b0; fifo_full_i = 1'b0;
        repeat (3) step_cycle();
        vectors++; if (adc_cs_n_o !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n_o); end
        vectors++; if (adc_sclk_o !== 1'b1) begin miscompares++; $display("FAIL reset_sclk: got %b want 1", adc_sclk_o); end
        vectors++; if (wdata_o !== 12'h000) begin miscompares++; $display("FAIL reset_wdata: got %h want 000", wdata_o); end
        vectors++; if (wren_o !== 1'b0) begin miscompares++; $display("FAIL reset_wren: got %b want 0", wren_o); end
        vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err_o); end
        rst = 1'b0;
        step_cycle();
    endtask

    task automatic test_single();
        bit ok;
        int start;
        adc_word = 16'h0ABC;
        clear_stats();
        start = cyc;
        en_i  = 1'b1;
        wait_wren(400, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL single_timeout: got no wren want wren"); end
        // First edge samples en_i, then CS_SETUP(4) + SHIFT(128) edges before DONE is visible.
        vectors++; if (cyc - start !== 133) begin miscompares++; $display("FAIL single_latency: got %0d want 133", cyc - start); end
        vectors++; if (wdata_o !== 12'hABC) begin miscompares++; $display("FAIL single_wdata: got %h want abc", wdata_o); end
        vectors++; if (cs_low !== 132) begin miscompares++; $display("FAIL single_cs_low: got %0d want 132", cs_low); end
        vectors++; if (rises !== 16) begin miscompares++; $display("FAIL single_sclk_rises: got %0d want 16", rises); end
        vectors++; if (wren_cnt !== 1) begin miscompares++; $display("FAIL single_wren_count: got %0d want 1", wren_cnt); end
        en_i = 1'b0;
        step_cycle();
        vectors++; if (wren_o !== 1'b0) begin miscompares++; $display("FAIL single_wren_pulse: got %b want 0", wren_o); end
        repeat (8) step_cycle();
        vectors++; if (adc_cs_n_o !== 1'b1) begin miscompares++; $display("FAIL single_idle_cs: got %b want 1", adc_cs_n_o); end
    endtask

    task automatic test_continuous();
        bit ok;
        int t0;
        logic [15:0] words [3];
        logic [11:0] exp   [3];
        words[0] = 16'h0000; words[1] = 16'h0FFF; words[2] = 16'h0555;
        exp[0]   = 12'h000;  exp[1]   = 12'hFFF;  exp[2]   = 12'h555;
        adc_word = words[0];
        en_i     = 1'b1;
        t0       = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_wren(400, ok);
            vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL cont_timeout_%0d: got no wren want wren", k); end
            vectors++; if (wdata_o !== exp[k]) begin miscompares++; $display("FAIL cont_wdata_%0d: got %h want %h", k, wdata_o, exp[k]); end
            if (k > 0) begin
                vectors++; if (cyc - t0 !== 135) begin miscompares++; $display("FAIL cont_period_%0d: got %0d want 135", k, cyc - t0); end
            end
            t0 = cyc;
            if (k < 2) adc_word = words[k+1];
        end
        en_i = 1'b0;
        vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL cont_drop: got %0d want 0", drop_cnt_o); end
        repeat (10) step_cycle();
    endtask

    task automatic test_full();
        bit ok;
        adc_word    = 16'h0123;
        fifo_full_i = 1'b1;
        clear_stats();
        en_i = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            step_cycle();
            if (drop_cnt_o === 8'd3) ok = 1'b1;
        end
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_drop3: got %0d want 3", drop_cnt_o); end
        vectors++; if (wren_cnt !== 0) begin miscompares++; $display("FAIL full_no_wren: got %0d want 0", wren_cnt); end
        vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL full_overrun: got %b want 1", overrun_o); end
        fifo_full_i = 1'b0;
        wait_wren(200, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_resume: got no wren want wren"); end
        vectors++; if (wdata_o !== 12'h123) begin miscompares++; $display("FAIL full_resume_wdata: got %h want 123", wdata_o); end
        vectors++; if (drop_cnt_o !== 8'd3) begin miscompares++; $display("FAIL full_resume_drop: got %0d want 3", drop_cnt_o); end
        fifo_full_i = 1'b1;
        clear_stats();
        repeat (300 * 135) step_cycle();
        vectors++; if (drop_cnt_o !== 8'd255) begin miscompares++; $display("FAIL full_saturate: got %0d want 255", drop_cnt_o); end
        vectors++; if (wren_cnt !== 0) begin miscompares++; $display("FAIL full_sat_no_wren: got %0d want 0", wren_cnt); end
        // Land clr_i on the edge that enters the next DONE, one full period after this one.
        wait_frame_end(300, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_align: got no frame end want frame end"); end
        repeat (134) step_cycle();
        clr_i = 1'b1;
        step_cycle();
        clr_i = 1'b0;
        en_i  = 1'b0;
        fifo_full_i = 1'b0;
        vectors++; if (drop_cnt_o !== 8'd1) begin miscompares++; $display("FAIL clr_with_drop_cnt: got %0d want 1", drop_cnt_o); end
        vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL clr_with_drop_overrun: got %b want 1", overrun_o); end
        repeat (10) step_cycle();
    endtask

    task automatic test_frame_err();
        bit ok;
        adc_word = 16'h8123;
        clear_stats();
        en_i = 1'b1;
        wait_frame_end(300, ok);
        en_i = 1'b0;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL err_timeout: got no frame end want frame end"); end
        vectors++; if (frame_err_o !== 1'b1) begin miscompares++; $display("FAIL err_flag: got %b want 1", frame_err_o); end
        vectors++; if (wren_cnt !== 0) begin miscompares++; $display("FAIL err_no_wren: got %0d want 0", wren_cnt); end
        repeat (5) step_cycle();
        clr_i = 1'b1;
        step_cycle();
        clr_i = 1'b0;
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL err_clr: got %b want 0", frame_err_o); end
        vectors++; if (drop_cnt_o !== 8'd0) begin miscompares++; $display("FAIL err_clr_drop: got %0d want 0", drop_cnt_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL err_clr_overrun: got %b want 0", overrun_o); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        adc_word = 16'h0ABC;
        clear_stats();
        en_i = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step_cycle();
            if (rises == 7) ok = 1'b1;
        end
        repeat (2) step_cycle();
        clear_stats();
        rst = 1'b1;
        step_cycle();
        vectors++; if (adc_cs_n_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_cs: got %b want 1", adc_cs_n_o); end
        vectors++; if (adc_sclk_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_sclk: got %b want 1", adc_sclk_o); end
        step_cycle();
        rst = 1'b0;
        vectors++; if (wren_cnt !== 0) begin miscompares++; $display("FAIL rst_mid_no_wren: got %0d want 0", wren_cnt); end
        clear_stats();
        wait_wren(400, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rst_recover_timeout: got no wren want wren"); end
        vectors++; if (wdata_o !== 12'hABC) begin miscompares++; $display("FAIL rst_recover_wdata: got %h want abc", wdata_o); end
        vectors++; if (rises !== 16) begin miscompares++; $display("FAIL rst_recover_rises: got %0d want 16", rises); end
        en_i = 1'b0;
        repeat (10) step_cycle();
    endtask

    task automatic test_en_drop();
        bit ok;
        adc_word = 16'h0321;
        clear_stats();
        en_i = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step_cycle();
            if (rises == 3) ok = 1'b1;
        end
        en_i = 1'b0;
        wait_wren(200, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL en_drop_timeout: got no wren want wren"); end
        vectors++; if (wdata_o !== 12'h321) begin miscompares++; $display("FAIL en_drop_wdata: got %h want 321", wdata_o); end
        clear_stats();
        repeat (300) step_cycle();
        vectors++; if (rises !== 0) begin miscompares++; $display("FAIL en_drop_no_sclk: got %0d want 0", rises); end
        vectors++; if (adc_cs_n_o !== 1'b1) begin miscompares++; $display("FAIL en_drop_idle_cs: got %b want 1", adc_cs_n_o); end
        vectors++; if (wren_cnt !== 0) begin miscompares++; $display("FAIL en_drop_no_wren: got %0d want 0", wren_cnt); end
    endtask

    initial begin
        rst         = 1'b1;
        en_i        = 1'b0;
        clr_i       = 1'b0;
        fifo_full_i = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_full();
        test_frame_err();
        test_rst_mid();
        test_en_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
